// File: rtl/axis_rotate_arb.sv
// Packet-level round-robin arbiter in front of a shared AXI Stream byte-rotate datapath.
// Optional feature macro: AXIS_ROTATE_ARB_CMD_LOCK_EN (hold the first-beat rotate command for the whole packet).
module axis_rotate_arb #(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned USER_WIDTH = 64
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_PORTS*USER_WIDTH-1:0]   s_axis_tuser,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]              s_axis_tlast,
   output logic [NUM_PORTS-1:0]              s_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [USER_WIDTH-1:0]             m_axis_tuser,
   output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
   output logic [$clog2(NUM_PORTS)-1:0]      m_axis_tid,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready
);

   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned ID_WIDTH   = $clog2(NUM_PORTS);

   typedef enum logic {
      ST_ARB = 1'b0,
      ST_PKT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   gnt_q, gnt_d;
   logic [ID_WIDTH-1:0]   last_q, last_d;
   logic [ID_WIDTH-1:0]   winner;

   logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];
   logic [USER_WIDTH-1:0] port_user [NUM_PORTS];
   logic [KEEP_WIDTH-1:0] port_keep [NUM_PORTS];

   logic [DATA_WIDTH-1:0] sel_data;
   logic [USER_WIDTH-1:0] sel_user;
   logic [KEEP_WIDTH-1:0] sel_keep;
   logic                  sel_valid;
   logic                  sel_last;
   logic [USER_WIDTH-1:0] beat_user;

   logic                  slot_free;
   logic                  accept;
   logic                  arb_win;

   logic [DATA_WIDTH-1:0] tdata_d;
   logic [USER_WIDTH-1:0] tuser_d;
   logic [KEEP_WIDTH-1:0] tkeep_d;
   logic [ID_WIDTH-1:0]   tid_d;
   logic                  tvalid_d;
   logic                  tlast_d;

   // Split the flat input buses into per-port slices.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign port_data[p] = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
      assign port_user[p] = s_axis_tuser[p*USER_WIDTH +: USER_WIDTH];
      assign port_keep[p] = s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
   end

   // First requester strictly after ptr, wrapping; ptr itself is checked last.
   function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                    input logic [ID_WIDTH-1:0]  ptr);
      logic [ID_WIDTH-1:0] pick;
      logic                found;
      int unsigned         idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         idx = (32'(ptr) + i) % NUM_PORTS;
         if (!found && req[ID_WIDTH'(idx)]) begin
            found = 1'b1;
            pick  = ID_WIDTH'(idx);
         end
      end
      return pick;
   endfunction

   assign winner    = rr_pick(s_axis_tvalid, last_q);
   assign sel_data  = port_data[gnt_q];
   assign sel_user  = port_user[gnt_q];
   assign sel_keep  = port_keep[gnt_q];
   assign sel_valid = s_axis_tvalid[gnt_q];
   assign sel_last  = s_axis_tlast[gnt_q];

   // The output register can take a beat when it is empty or draining this cycle.
   assign slot_free = m_axis_tready | ~m_axis_tvalid;
   assign accept    = (state_q == ST_PKT) && sel_valid && slot_free;
   assign arb_win   = (state_q == ST_ARB) && (|s_axis_tvalid);

`ifdef AXIS_ROTATE_ARB_CMD_LOCK_EN
   localparam int unsigned CMD_BITS = $clog2(DATA_WIDTH / 8) + 1;

   logic [CMD_BITS-1:0] cmd_q, cmd_d;
   logic                first_q, first_d;

   // Latch the command of the packet's first beat and replay it on later beats.
   always_comb begin
      cmd_d     = cmd_q;
      first_d   = first_q;
      beat_user = sel_user;
      if (!first_q) begin
         beat_user[CMD_BITS-1:0] = cmd_q;
      end
      if (arb_win) begin
         first_d = 1'b1;
      end else if (accept) begin
         first_d = 1'b0;
         if (first_q) begin
            cmd_d = sel_user[CMD_BITS-1:0];
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         cmd_q   <= '0;
         first_q <= 1'b0;
      end else begin
         cmd_q   <= cmd_d;
         first_q <= first_d;
      end
   end
`else
   assign beat_user = sel_user;
`endif

   // Next-state, grant bookkeeping, per-port ready and output register load.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      last_d        = last_q;
      s_axis_tready = '0;
      tdata_d       = m_axis_tdata;
      tuser_d       = m_axis_tuser;
      tkeep_d       = m_axis_tkeep;
      tid_d         = m_axis_tid;
      tvalid_d      = m_axis_tvalid;
      tlast_d       = m_axis_tlast;

      case (state_q)
         ST_ARB: begin
            if (arb_win) begin
               gnt_d   = winner;
               last_d  = winner;
               state_d = ST_PKT;
            end
         end
         ST_PKT: begin
            s_axis_tready[gnt_q] = slot_free;
            if (accept && sel_last) begin
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase

      if (accept) begin
         tdata_d  = sel_data;
         tuser_d  = beat_user;
         tkeep_d  = sel_keep;
         tid_d    = gnt_q;
         tlast_d  = sel_last;
         tvalid_d = 1'b1;
      end else if (slot_free) begin
         tvalid_d = 1'b0;
      end
   end

   // Reset leaves port 0 with first priority and drops any partial packet.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q       <= ST_ARB;
         gnt_q         <= '0;
         last_q        <= ID_WIDTH'(NUM_PORTS - 1);
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tid    <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         last_q        <= last_d;
         m_axis_tdata  <= tdata_d;
         m_axis_tuser  <= tuser_d;
         m_axis_tkeep  <= tkeep_d;
         m_axis_tid    <= tid_d;
         m_axis_tvalid <= tvalid_d;
         m_axis_tlast  <= tlast_d;
      end
   end

endmodule

// File: doc/axis_rotate_arb.md
# axis_rotate_arb

Packet-level round-robin arbiter that shares one downstream AXI Stream byte-rotate datapath between NUM_PORTS requesters. It sits directly in front of the rotator and does three things:
- grants one input stream at a time and holds the grant until that packet's tlast;
- forwards the requester's rotate command on tuser;
- tags every output beat with the source port index on m_axis_tid, so the return path can demultiplex.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesting streams (min 2).
- DATA_WIDTH, 64, tdata width in bits, multiple of 8.
- USER_WIDTH, 64, tuser width. Must be ≥ CMD_BITS = $clog2(DATA_WIDTH/8)+1.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tuser  in  NUM_PORTS*USER_WIDTH  per-port; low CMD_BITS = rotate command (direction bit + byte count).
- s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of packet.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  to rotator.
- m_axis_tuser  out  USER_WIDTH  to rotator (rotate command).
- m_axis_tkeep  out  DATA_WIDTH/8  to rotator.
- m_axis_tid  out  $clog2(NUM_PORTS)  source port of current beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tready  in  1  rotator ready.

## Operation
- FSM states:
  - ARB: no grant held; all s_axis_tready = 0.
  - PKT: grant held by port gnt.
- Arbitration (in ARB):
  - Search tvalid starting at port (last+1) mod NUM_PORTS, wrapping; the first asserted port wins.
  - Register gnt = last = winner and move to PKT.
  - If no tvalid is asserted, stay in ARB.
- Transfer (in PKT):
  - s_axis_tready[gnt] = slot_free, where slot_free = m_axis_tready | ~m_axis_tvalid.
  - All other readies are 0.
- Accept: s_axis_tvalid[gnt] & slot_free loads the output register with the gnt slices of tdata/tuser/tkeep/tlast, tid = gnt, tvalid = 1.
- Empty slot: if slot_free and there is no accept, m_axis_tvalid ← 0.
- End of packet: accepting a beat with tlast = 1 returns the FSM to ARB. `last` keeps that port, so it gets lowest priority in the next search.
- Mid-packet: a tvalid drop on the granted port holds PKT (bubbles on output). The grant is never revoked before tlast.
- tuser bits above CMD_BITS pass through unmodified.

## Timing
- Reset values: m_axis_tdata/tuser/tkeep/tid = 0, m_axis_tvalid = 0, m_axis_tlast = 0, s_axis_tready = 0.
- State after reset: state = ARB, last = NUM_PORTS-1, so port 0 has first priority.
- Reset asserted mid-packet aborts the packet immediately (partial packet dropped, output cleared).
- Arbitration costs one cycle:
  - tvalid seen in cycle N (ARB) → tready in N+1 → beat on m_axis in N+2 at the earliest.
  - Each packet incurs exactly one ARB bubble cycle.
- Throughput: one beat per cycle while in PKT with continuous valid/ready.
- Output is a single register stage.
  - m_axis_tvalid never drops without a handshake.
  - Data on the m_axis outputs is stable while tvalid & ~tready.
- Simultaneous requests are resolved only by the rotating pointer. There are no fixed priorities.

## Configuration
- AXIS_ROTATE_ARB_CMD_LOCK_EN defined:
  - The low CMD_BITS of tuser are captured from the first beat of each packet.
  - That captured command is driven on m_axis_tuser for every beat of the packet; later-beat command bits are ignored.
  - Upper bits still pass per beat.
- Not defined: tuser passes through per beat unchanged.

## Test plan
- Reset then idle: no tvalid for 10 cycles → all s_axis_tready = 0, m_axis_tvalid = 0, outputs all zero.
- Port 2 alone sends a 3-beat packet with tuser = 3, m_axis_tready = 1:
  - tready[2] rises 1 cycle after tvalid;
  - 3 beats out with tid = 2, tuser = 3, tlast on beat 3;
  - ARB for 1 cycle afterwards.
- All 4 ports request continuously with 2-beat packets → grant order 0,1,2,3,0; each packet's beats are contiguous with the correct tid.
- Backpressure: m_axis_tready low for 5 cycles mid-packet → m_axis data held stable, tready[gnt] = 0, no beat lost or duplicated.
- Granted port drops tvalid for 3 cycles mid-packet while port 1 requests → no switch until granted tlast; port 1 served next.
- With macro: beat 1 tuser = 9, beats 2–3 tuser = 2 → all output beats carry command 9. Without macro: outputs 9, 2, 2.
